// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix-multiply memory responder.
// Holds the default geometry, the responder state encoding and the address decode.
package matrix_pkg;

  localparam int          W         = 32;
  localparam int          N         = 4;
  localparam int          DEPTH     = 2 * N * N;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int          LATENCY   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word index of a byte address; addresses below base wrap to a huge index.
  function automatic logic [31:0] addr_to_idx(input logic [31:0] addr,
                                              input logic [31:0] base);
    logic [31:0] offset;
    offset = addr - base;
    return offset >> 2;
  endfunction

endpackage

// File: rtl/matrix_mem_array.sv
// Word storage: one synchronous write port, a registered response read port
// and a combinational host read port.
module matrix_mem_array #(
  parameter int DEPTH = 32,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd_en,
  input  logic                     rd_zero,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  output logic [W-1:0]             host_rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; clearing it would force a flop-based
  // array and it must survive a transaction abort anyway.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-first: a word written in the same cycle it is read returns the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      if (rd_zero) begin
        rdata <= '0;
      end else if (we && (waddr == raddr)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem[raddr];
      end
    end
  end

  assign host_rdata = mem[host_addr];

endmodule

// File: rtl/matrix_mem_responder.sv
// Word-addressed memory responder for the matrix core: start/done transaction
// port with fixed latency plus a host preload/readback port usable while idle.
module matrix_mem_responder #(
  parameter int          DEPTH     = matrix_pkg::DEPTH,
  parameter int          W         = matrix_pkg::W,
  parameter logic [31:0] BASE_ADDR = matrix_pkg::BASE_ADDR,
  parameter int          LATENCY   = matrix_pkg::LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_start,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [W-1:0]             req_wdata,
  output logic                     rsp_done,
  output logic [W-1:0]             rsp_rdata,
  output logic                     rsp_err,
  output logic                     host_ready,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [W-1:0]             host_wdata,
  output logic [W-1:0]             host_rdata
);

  import matrix_pkg::*;

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt;

  logic           cap_write;
  logic           cap_err;
  logic [AW-1:0]  cap_idx;
  logic [W-1:0]   cap_wdata;

  logic [31:0]    req_idx;
  logic           req_err;
  logic           accept;
  logic           enter_resp;

  logic           cur_write;
  logic           cur_err;
  logic [AW-1:0]  cur_idx;

  logic           store_en;
  logic           host_acc;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [W-1:0]   wr_data;

  // Live decode of the request presented this cycle.
  assign req_idx = addr_to_idx(req_addr, BASE_ADDR);
  assign req_err = (req_addr[1:0] != 2'b00) || (req_idx >= DEPTH_U);
  assign accept  = (state == IDLE) && req_start;

  // With zero latency the response is entered straight from IDLE, so the
  // live request fields are used instead of the captured ones.
  assign cur_write = (state == IDLE) ? req_write          : cap_write;
  assign cur_err   = (state == IDLE) ? req_err            : cap_err;
  assign cur_idx   = (state == IDLE) ? req_idx[AW-1:0]    : cap_idx;

  assign enter_resp = (state_next == RESP) && (state != RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    state_next = state;
    unique case (state)
      IDLE: if (req_start) state_next = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (cnt == CW'(1)) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rsp_done   = 1'b0;
    host_ready = 1'b0;
    store_en   = 1'b0;
    unique case (state)
      IDLE: host_ready = 1'b1;
      RESP: begin
        rsp_done = 1'b1;
        store_en = cap_write && !cap_err && !rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CW'(LATENCY);
    end else if (state == WAIT) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Request fields are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write <= req_write;
      cap_err   <= req_err;
      cap_idx   <= req_idx[AW-1:0];
      cap_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= enter_resp && cur_err;
    end
  end

  // Host writes only happen in IDLE and stores only in RESP, so they never collide.
  assign host_acc = host_we && host_ready;
  assign wr_en    = host_acc || store_en;
  assign wr_addr  = store_en ? cap_idx   : host_addr;
  assign wr_data  = store_en ? cap_wdata : host_wdata;

  matrix_mem_array #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .we         (wr_en),
    .waddr      (wr_addr),
    .wdata      (wr_data),
    .rd_en      (enter_resp && !cur_write),
    .rd_zero    (cur_err),
    .raddr      (cur_idx),
    .rdata      (rsp_rdata),
    .host_addr  (host_addr),
    .host_rdata (host_rdata)
  );

endmodule
